// File: rtl/uart_case_stream.sv
// uart_case_stream: case-transform stage feeding a show-ahead byte FIFO
// between the UART receiver and transmitter. Overflow drops are counted
// (saturating) and flagged sticky until i_clr.
// Optional CR->CRLF expansion is compiled in with `define UART_CASE_CRLF_EN.
//
// CRLF FSM (only with UART_CASE_CRLF_EN):
//   state   | meaning
//   IDLE    | accepting bytes; a CR needs room for itself plus the LF
//   EMIT_LF | pushing the reserved LF; input is not accepted
module uart_case_stream #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_mode,
  input  logic [7:0]       i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [7:0]       o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [AW:0]      o_level,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_drop_cnt,
  output logic             o_overflow,
  input  logic             i_clr
);

  localparam int          DEPTH_M1 = DEPTH - 1;
  localparam int          DEPTH_M2 = DEPTH - 2;
  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];
  localparam logic [AW:0] LVL_M1   = DEPTH_M1[AW:0];
  localparam logic [AW:0] LVL_M2   = DEPTH_M2[AW:0];

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop, in_ready;
  logic [7:0]       push_data;

  function automatic logic [7:0] xform(input logic [1:0] mode, input logic [7:0] d);
    logic is_lo, is_up;
    is_lo = (d >= 8'h61) && (d <= 8'h7A);
    is_up = (d >= 8'h41) && (d <= 8'h5A);
    if (mode[0] && is_lo)      return d - 8'h20;
    else if (mode[1] && is_up) return d + 8'h20;
    else                       return d;
  endfunction

  assign o_full      = (level_q == LVL_FULL);
  assign o_empty     = (level_q == '0);
  assign o_out_valid = !o_empty;
  assign o_out_data  = o_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign o_level     = level_q;
  assign o_drop_cnt  = drop_cnt_q;
  assign o_overflow  = overflow_q;
  assign o_in_ready  = in_ready;
  assign pop         = o_out_valid && i_out_ready;

`ifdef UART_CASE_CRLF_EN
  typedef enum logic {IDLE, EMIT_LF} state_t;
  state_t state_q, state_d;

  // Push/drop decision with CR expansion; a CR only enters when the LF fits too.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == IDLE);
    push      = 1'b0;
    drop      = 1'b0;
    push_data = xform(i_mode, i_in_data);
    case (state_q)
      EMIT_LF: begin
        push      = 1'b1;
        push_data = 8'h0A;
        drop      = i_in_valid;
        state_d   = IDLE;
      end
      default: begin
        if (i_in_valid) begin
          if (i_in_data == 8'h0D) begin
            if ((level_q <= LVL_M2) || (pop && (level_q <= LVL_M1))) begin
              push      = 1'b1;
              push_data = 8'h0D;
              state_d   = EMIT_LF;
            end else begin
              drop = 1'b1;
            end
          end else if (!o_full || pop) begin
            push = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
    endcase
  end

  // CRLF state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
`else
  // Push/drop decision: a full FIFO still accepts when it pops in the same cycle.
  always_comb begin
    in_ready  = 1'b1;
    push_data = xform(i_mode, i_in_data);
    push      = i_in_valid && (!o_full || pop);
    drop      = i_in_valid && !push;
  end
`endif

  // Pointer, level and drop-counter next state; clear beats a same-cycle drop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, pop};
    level_d    = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (i_clr) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}})
        drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since the level gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_uart_case_stream.sv
// Self-checking bench for uart_case_stream: directed steps plus random
// traffic compared against a queue-based reference model.
module tb_uart_case_stream;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       i_mode = 2'd0;
  logic [7:0]       i_in_data = 8'h00;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [7:0]       o_out_data;
  logic             o_out_valid;
  logic             i_out_ready = 1'b0;
  logic [AW:0]      o_level;
  logic             o_full;
  logic             o_empty;
  logic [CNT_W-1:0] o_drop_cnt;
  logic             o_overflow;
  logic             i_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mq[$];
  int         m_drop = 0;
  bit         m_ov   = 0;
  bit         m_lf   = 0;

  uart_case_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_in_data(i_in_data),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_out_data(o_out_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_level(o_level),
    .o_full(o_full), .o_empty(o_empty), .o_drop_cnt(o_drop_cnt),
    .o_overflow(o_overflow), .i_clr(i_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_xform(input logic [1:0] m, input logic [7:0] d);
    int v = int'(d);
    if ((m == 2'd1 || m == 2'd3) && v >= 97 && v <= 122) return 8'(v - 32);
    if ((m == 2'd2 || m == 2'd3) && v >= 65 && v <= 90)  return 8'(v + 32);
    return d;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(o_level), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(o_empty), 32'(mq.size() == 0));
    chk({tag, ".full"}, 32'(o_full), 32'(mq.size() == DEPTH));
    chk({tag, ".valid"}, 32'(o_out_valid), 32'(mq.size() != 0));
    chk({tag, ".data"}, 32'(o_out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, ".drop"}, 32'(o_drop_cnt), 32'(m_drop));
    chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ov));
    chk({tag, ".rdy"}, 32'(o_in_ready), 32'(!m_lf));
  endtask

  // One clock: drive at negedge, advance model, check 1 ns after the edge.
  task automatic step(input bit v, input logic [7:0] d, input logic [1:0] m,
                      input bit r, input bit c, input string tag);
    int   sz;
    bit   pop, push, drop;
    logic [7:0] pd;
    @(negedge clk);
    i_in_valid = v; i_in_data = d; i_mode = m; i_out_ready = r; i_clr = c;
    sz = mq.size();
    pop = (sz > 0) && r;
    push = 0; drop = 0; pd = ref_xform(m, d);
`ifdef UART_CASE_CRLF_EN
    if (m_lf) begin
      push = 1; pd = 8'h0A; drop = v; m_lf = 0;
    end else if (v && d == 8'h0D) begin
      if (DEPTH - sz + int'(pop) >= 2) begin push = 1; pd = 8'h0D; m_lf = 1; end
      else drop = 1;
    end else if (v) begin
      if (sz < DEPTH || pop) push = 1; else drop = 1;
    end
`else
    if (v) begin
      if (sz < DEPTH || pop) push = 1; else drop = 1;
    end
`endif
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(pd);
    if (c) begin
      m_drop = 0; m_ov = 0;
    end else if (drop) begin
      m_ov = 1;
      if (m_drop < (1 << CNT_W) - 1) m_drop++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    i_in_valid = 1'b1; i_in_data = 8'h61; i_out_ready = 1'b0; i_clr = 1'b0;
    mq.delete(); m_drop = 0; m_ov = 0; m_lf = 0;
    #2;
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
    i_in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int sel;

    // reset from power-up
    do_reset("rst0");

    // upper mode, streaming with ready
    step(1, 8'h61, 2'd1, 1, 0, "up0"); chk("up0_head", 32'(o_out_data), 32'h41);
    step(1, 8'h7B, 2'd1, 1, 0, "up1"); chk("up1_head", 32'(o_out_data), 32'h7B);
    step(1, 8'h41, 2'd1, 1, 0, "up2"); chk("up2_head", 32'(o_out_data), 32'h41);
    step(0, 8'h00, 2'd1, 1, 0, "up3"); chk("up3_empty", 32'(o_empty), 32'd1);

    // toggle then lower
    step(1, 8'h41, 2'd3, 1, 0, "tg0"); chk("tg0_head", 32'(o_out_data), 32'h61);
    step(1, 8'h7A, 2'd3, 1, 0, "tg1"); chk("tg1_head", 32'(o_out_data), 32'h5A);
    step(1, 8'h35, 2'd3, 1, 0, "tg2"); chk("tg2_head", 32'(o_out_data), 32'h35);
    step(1, 8'h5A, 2'd2, 1, 0, "lo0"); chk("lo0_head", 32'(o_out_data), 32'h7A);
    step(0, 8'h00, 2'd0, 1, 0, "lo1");

    // overflow: 17 pushes with no drain
    for (int i = 0; i < 17; i++) step(1, 8'(8'h30 + i), 2'd0, 0, 0, "ovf_fill");
    chk("ovf_level", 32'(o_level), 32'd16);
    chk("ovf_full", 32'(o_full), 32'd1);
    chk("ovf_drop", 32'(o_drop_cnt), 32'd1);
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", 32'(o_out_data), 32'(8'h30 + i));
      step(0, 8'h00, 2'd0, 1, 0, "ovf_drain_step");
    end
    step(0, 8'h00, 2'd0, 0, 1, "clr");
    chk("clr_drop", 32'(o_drop_cnt), 32'd0);
    chk("clr_flag", 32'(o_overflow), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1, 8'(i), 2'd0, 0, 0, "fp_fill");
    step(1, 8'hAA, 2'd0, 1, 0, "fp_both");
    chk("fp_level", 32'(o_level), 32'd16);
    chk("fp_drop", 32'(o_drop_cnt), 32'd0);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 2'd0, 1, 0, "fp_drain");
    chk("fp_tail", 32'(o_out_data), 32'hAA);
    step(0, 8'h00, 2'd0, 1, 0, "fp_last");

    // drop counter saturation and clear priority over a drop
    for (int i = 0; i < 16; i++) step(1, 8'h55, 2'd0, 0, 0, "sat_fill");
    for (int i = 0; i < 300; i++) step(1, 8'h66, 2'd0, 0, 0, "sat_drop");
    chk("sat_cnt", 32'(o_drop_cnt), 32'hFF);
    step(1, 8'h66, 2'd0, 0, 1, "clr_vs_drop");
    chk("clr_vs_drop_cnt", 32'(o_drop_cnt), 32'd0);

    // reset mid-stream discards buffered data
    do_reset("rst_mid");
    chk("rst_mid_lvl", 32'(o_level), 32'd0);
    step(0, 8'h00, 2'd0, 1, 0, "post_rst");

`ifdef UART_CASE_CRLF_EN
    // CR followed immediately by a byte: that byte is dropped
    step(1, 8'h0D, 2'd1, 0, 0, "cr0");
    chk("cr0_rdy", 32'(o_in_ready), 32'd0);
    step(1, 8'h62, 2'd1, 0, 0, "cr1");
    chk("cr1_lvl", 32'(o_level), 32'd2);
    chk("cr1_drop", 32'(o_drop_cnt), 32'd1);
    chk("cr1_head", 32'(o_out_data), 32'h0D);
    step(0, 8'h00, 2'd0, 1, 1, "cr2");
    chk("cr2_head", 32'(o_out_data), 32'h0A);
    step(0, 8'h00, 2'd0, 1, 0, "cr3");
    // CR with a gap before the next byte: no drop
    step(1, 8'h0D, 2'd1, 0, 0, "cr4");
    step(0, 8'h00, 2'd1, 0, 0, "cr5");
    step(1, 8'h62, 2'd1, 0, 0, "cr6");
    chk("cr6_lvl", 32'(o_level), 32'd3);
    chk("cr6_drop", 32'(o_drop_cnt), 32'd0);
    step(0, 8'h00, 2'd0, 1, 0, "cr7"); chk("cr7_head", 32'(o_out_data), 32'h0A);
    step(0, 8'h00, 2'd0, 1, 0, "cr8"); chk("cr8_head", 32'(o_out_data), 32'h42);
    step(0, 8'h00, 2'd0, 1, 0, "cr9");
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0: rd = 8'($urandom_range(97, 122));
        1: rd = 8'($urandom_range(65, 90));
        2: rd = 8'h0D;
        default: rd = 8'($urandom_range(0, 255));
      endcase
      step(bit'($urandom_range(0, 3) != 0), rd, 2'($urandom_range(0, 3)),
           bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 60) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
